// File: rtl/resource_update_sequencer_if.sv
// Request, table-update and result signals of the resource update sequencer.
// The slave modport is the sequencer's view; master is the allocator/table side.
interface resource_update_sequencer_if #(
    parameter int CU_ID_WIDTH      = 1,
    parameter int WF_SLOT_ID_WIDTH = 4,
    parameter int RES_ID_WIDTH     = 4
) ();
    // Handshakes: a request moves on a rising edge where valid && ready are both 1;
    // the requester holds its fields stable while valid is high and ready is low.
    logic                        alloc_req_valid;
    logic                        alloc_req_ready;
    logic [CU_ID_WIDTH-1:0]      alloc_req_cu_id;
    logic [WF_SLOT_ID_WIDTH-1:0] alloc_req_wf_slot_id;
    logic [RES_ID_WIDTH-1:0]     alloc_req_res_start;
    logic [RES_ID_WIDTH-1:0]     alloc_req_res_size;

    logic                        dealloc_req_valid;
    logic                        dealloc_req_ready;
    logic [CU_ID_WIDTH-1:0]      dealloc_req_cu_id;
    logic [WF_SLOT_ID_WIDTH-1:0] dealloc_req_wf_slot_id;

    logic                        alloc_res_en;
    logic                        dealloc_res_en;
    logic [CU_ID_WIDTH-1:0]      alloc_cu_id;
    logic [WF_SLOT_ID_WIDTH-1:0] alloc_wf_slot_id;
    logic [RES_ID_WIDTH-1:0]     alloc_res_start;
    logic [RES_ID_WIDTH-1:0]     alloc_res_size;
    logic [CU_ID_WIDTH-1:0]      dealloc_cu_id;
    logic [WF_SLOT_ID_WIDTH-1:0] dealloc_wf_slot_id;

    logic                        res_table_done;
    logic [RES_ID_WIDTH-1:0]     cam_biggest_space_size;
    logic [RES_ID_WIDTH-1:0]     cam_biggest_space_addr;

    logic                        update_done;
    logic                        update_was_alloc;
    logic [CU_ID_WIDTH-1:0]      update_cu_id;
    logic [RES_ID_WIDTH-1:0]     biggest_space_size;
    logic [RES_ID_WIDTH-1:0]     biggest_space_addr;
    logic                        seq_busy;

    modport slave (
        input  alloc_req_valid, alloc_req_cu_id, alloc_req_wf_slot_id,
               alloc_req_res_start, alloc_req_res_size,
               dealloc_req_valid, dealloc_req_cu_id, dealloc_req_wf_slot_id,
               res_table_done, cam_biggest_space_size, cam_biggest_space_addr,
        output alloc_req_ready, dealloc_req_ready,
               alloc_res_en, dealloc_res_en,
               alloc_cu_id, alloc_wf_slot_id, alloc_res_start, alloc_res_size,
               dealloc_cu_id, dealloc_wf_slot_id,
               update_done, update_was_alloc, update_cu_id,
               biggest_space_size, biggest_space_addr, seq_busy
    );

    modport master (
        output alloc_req_valid, alloc_req_cu_id, alloc_req_wf_slot_id,
               alloc_req_res_start, alloc_req_res_size,
               dealloc_req_valid, dealloc_req_cu_id, dealloc_req_wf_slot_id,
               res_table_done, cam_biggest_space_size, cam_biggest_space_addr,
        input  alloc_req_ready, dealloc_req_ready,
               alloc_res_en, dealloc_res_en,
               alloc_cu_id, alloc_wf_slot_id, alloc_res_start, alloc_res_size,
               dealloc_cu_id, dealloc_wf_slot_id,
               update_done, update_was_alloc, update_cu_id,
               biggest_space_size, biggest_space_addr, seq_busy
    );
endinterface

// File: rtl/resource_update_sequencer.sv
// Serializes allocations and buffered deallocations into one-at-a-time resource
// table updates, waiting for the table's done before issuing the next one.
module resource_update_sequencer #(
    parameter int CU_ID_WIDTH            = 1,
    parameter int WF_SLOT_ID_WIDTH       = 4,
    parameter int RES_ID_WIDTH           = 4,
    parameter int DEALLOC_FIFO_DEPTH     = 4,
    parameter int DEALLOC_FIFO_PTR_WIDTH = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    resource_update_sequencer_if.slave    bus,
    output logic                          dbg_state
);
    localparam int CNT_W = DEALLOC_FIFO_PTR_WIDTH + 1;

    typedef enum logic {
        IDLE      = 1'b0,
        WAIT_DONE = 1'b1
    } state_t;

    state_t state;
    state_t state_next;

    logic take_alloc;
    logic take_dealloc;
    logic done_fire;

    // Dealloc FIFO storage and bookkeeping
    logic [CU_ID_WIDTH-1:0]            fifo_cu   [DEALLOC_FIFO_DEPTH];
    logic [WF_SLOT_ID_WIDTH-1:0]       fifo_slot [DEALLOC_FIFO_DEPTH];
    logic [DEALLOC_FIFO_PTR_WIDTH-1:0] wr_ptr;
    logic [DEALLOC_FIFO_PTR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]                  fifo_count;
    logic                              fifo_empty;
    logic                              fifo_full;
    logic                              push;

    // Registered outputs
    logic                        alloc_res_en_q;
    logic                        dealloc_res_en_q;
    logic [CU_ID_WIDTH-1:0]      alloc_cu_id_q;
    logic [WF_SLOT_ID_WIDTH-1:0] alloc_wf_slot_id_q;
    logic [RES_ID_WIDTH-1:0]     alloc_res_start_q;
    logic [RES_ID_WIDTH-1:0]     alloc_res_size_q;
    logic [CU_ID_WIDTH-1:0]      dealloc_cu_id_q;
    logic [WF_SLOT_ID_WIDTH-1:0] dealloc_wf_slot_id_q;
    logic                        update_done_q;
    logic                        update_was_alloc_q;
    logic [CU_ID_WIDTH-1:0]      update_cu_id_q;
    logic [RES_ID_WIDTH-1:0]     biggest_size_q;
    logic [RES_ID_WIDTH-1:0]     biggest_addr_q;

    // Identity of the update currently in flight, reported when it completes
    logic                        cur_is_alloc;
    logic [CU_ID_WIDTH-1:0]      cur_cu_id;

    assign fifo_empty = (fifo_count == '0);
    assign fifo_full  = (fifo_count == CNT_W'(DEALLOC_FIFO_DEPTH));
    // Full refuses a push even when a pop happens in the same cycle.
    assign push       = bus.dealloc_req_valid && !fifo_full;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        take_alloc   = 1'b0;
        take_dealloc = 1'b0;
        done_fire    = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    take_dealloc = 1'b1;
                    state_next   = WAIT_DONE;
                end else if (bus.alloc_req_valid) begin
                    take_alloc = 1'b1;
                    state_next = WAIT_DONE;
                end
            end
            WAIT_DONE: begin
                if (bus.res_table_done) begin
                    done_fire  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (take_dealloc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, take_dealloc})
                2'b10:   fifo_count <= fifo_count + 1'b1;
                2'b01:   fifo_count <= fifo_count - 1'b1;
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_cu[wr_ptr]   <= bus.dealloc_req_cu_id;
            fifo_slot[wr_ptr] <= bus.dealloc_req_wf_slot_id;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            alloc_res_en_q       <= 1'b0;
            dealloc_res_en_q     <= 1'b0;
            alloc_cu_id_q        <= '0;
            alloc_wf_slot_id_q   <= '0;
            alloc_res_start_q    <= '0;
            alloc_res_size_q     <= '0;
            dealloc_cu_id_q      <= '0;
            dealloc_wf_slot_id_q <= '0;
            update_done_q        <= 1'b0;
            update_was_alloc_q   <= 1'b0;
            update_cu_id_q       <= '0;
            biggest_size_q       <= '0;
            biggest_addr_q       <= '0;
            cur_is_alloc         <= 1'b0;
            cur_cu_id            <= '0;
        end else begin
            alloc_res_en_q   <= take_alloc;
            dealloc_res_en_q <= take_dealloc;
            update_done_q    <= done_fire;
            if (take_alloc) begin
                alloc_cu_id_q      <= bus.alloc_req_cu_id;
                alloc_wf_slot_id_q <= bus.alloc_req_wf_slot_id;
                alloc_res_start_q  <= bus.alloc_req_res_start;
                alloc_res_size_q   <= bus.alloc_req_res_size;
                cur_is_alloc       <= 1'b1;
                cur_cu_id          <= bus.alloc_req_cu_id;
            end
            if (take_dealloc) begin
                dealloc_cu_id_q      <= fifo_cu[rd_ptr];
                dealloc_wf_slot_id_q <= fifo_slot[rd_ptr];
                cur_is_alloc         <= 1'b0;
                cur_cu_id            <= fifo_cu[rd_ptr];
            end
            if (done_fire) begin
                update_was_alloc_q <= cur_is_alloc;
                update_cu_id_q     <= cur_cu_id;
                biggest_size_q     <= bus.cam_biggest_space_size;
                biggest_addr_q     <= bus.cam_biggest_space_addr;
            end
        end
    end

    assign bus.alloc_req_ready    = (state == IDLE) && fifo_empty;
    assign bus.dealloc_req_ready  = !fifo_full;
    assign bus.alloc_res_en       = alloc_res_en_q;
    assign bus.dealloc_res_en     = dealloc_res_en_q;
    assign bus.alloc_cu_id        = alloc_cu_id_q;
    assign bus.alloc_wf_slot_id   = alloc_wf_slot_id_q;
    assign bus.alloc_res_start    = alloc_res_start_q;
    assign bus.alloc_res_size     = alloc_res_size_q;
    assign bus.dealloc_cu_id      = dealloc_cu_id_q;
    assign bus.dealloc_wf_slot_id = dealloc_wf_slot_id_q;
    assign bus.update_done        = update_done_q;
    assign bus.update_was_alloc   = update_was_alloc_q;
    assign bus.update_cu_id       = update_cu_id_q;
    assign bus.biggest_space_size = biggest_size_q;
    assign bus.biggest_space_addr = biggest_addr_q;
    assign bus.seq_busy           = (state != IDLE);
    assign dbg_state              = state;
endmodule

// File: tb/tb_resource_update_sequencer.sv
// Directed bench for resource_update_sequencer: vector table plus hand-written
// sequences for reset, priority, FIFO full/wrap and stray done pulses.
module tb_resource_update_sequencer;
    logic clk = 1'b0;
    logic rst;
    logic dbg_state;

    always #5 clk = ~clk;

    resource_update_sequencer_if #(
        .CU_ID_WIDTH(1), .WF_SLOT_ID_WIDTH(4), .RES_ID_WIDTH(4)
    ) bus ();

    resource_update_sequencer #(
        .CU_ID_WIDTH(1), .WF_SLOT_ID_WIDTH(4), .RES_ID_WIDTH(4),
        .DEALLOC_FIFO_DEPTH(4), .DEALLOC_FIFO_PTR_WIDTH(2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus),
        .dbg_state(dbg_state)
    );

    int checks   = 0;
    int failures = 0;

    // Scoreboards: {cu, slot} per expected dealloc strobe, {cu, slot, start, size} per alloc
    logic [4:0]  exp_q[$];
    logic [12:0] alloc_q[$];

    int   n_alloc   = 0;
    int   n_dealloc = 0;
    int   n_upd     = 0;
    logic prev_a    = 1'b0;
    logic prev_d    = 1'b0;
    logic prev_u    = 1'b0;

    logic [3:0] last_sz;
    logic [3:0] last_addr;

    typedef struct {
        logic       is_alloc;
        logic       cu;
        logic [3:0] slot;
        logic [3:0] start;
        logic [3:0] size;
        logic [3:0] cam_sz;
        logic [3:0] cam_addr;
        int         delay;
        logic       exp_ready;
        logic       exp_was_alloc;
        logic       exp_cu;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin : monitor
        logic [12:0] ea;
        logic [4:0]  ed;
        if (bus.alloc_res_en || bus.dealloc_res_en) begin
            check("strobes_exclusive", 32'(bus.alloc_res_en & bus.dealloc_res_en), 0);
        end
        if (bus.alloc_res_en) begin
            n_alloc++;
            check("alloc_strobe_one_cycle", 32'(prev_a), 0);
            check("alloc_q_nonempty", 32'(alloc_q.size() != 0), 1);
            if (alloc_q.size() != 0) begin
                ea = alloc_q.pop_front();
                check("alloc_fields", 32'({bus.alloc_cu_id, bus.alloc_wf_slot_id,
                                           bus.alloc_res_start, bus.alloc_res_size}), 32'(ea));
            end
        end
        if (bus.dealloc_res_en) begin
            n_dealloc++;
            check("dealloc_strobe_one_cycle", 32'(prev_d), 0);
            check("dealloc_q_nonempty", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                ed = exp_q.pop_front();
                check("dealloc_order", 32'({bus.dealloc_cu_id, bus.dealloc_wf_slot_id}), 32'(ed));
            end
        end
        if (bus.update_done) begin
            n_upd++;
            check("update_done_one_cycle", 32'(prev_u), 0);
        end
        prev_a = bus.alloc_res_en;
        prev_d = bus.dealloc_res_en;
        prev_u = bus.update_done;
    end

    // All driver tasks start and end just after a falling edge.
    task automatic push_dealloc(input logic cu, input logic [3:0] slot);
        bus.dealloc_req_valid      = 1'b1;
        bus.dealloc_req_cu_id      = cu;
        bus.dealloc_req_wf_slot_id = slot;
        check("dealloc_ready_at_push", 32'(bus.dealloc_req_ready), 1);
        exp_q.push_back({cu, slot});
        @(negedge clk);
        bus.dealloc_req_valid = 1'b0;
    endtask

    task automatic start_alloc(input logic cu, input logic [3:0] slot,
                               input logic [3:0] start, input logic [3:0] size);
        bus.alloc_req_valid      = 1'b1;
        bus.alloc_req_cu_id      = cu;
        bus.alloc_req_wf_slot_id = slot;
        bus.alloc_req_res_start  = start;
        bus.alloc_req_res_size   = size;
        alloc_q.push_back({cu, slot, start, size});
    endtask

    task automatic wait_strobe(input logic exp_alloc);
        int n = 0;
        while (!(bus.alloc_res_en || bus.dealloc_res_en) && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("strobe_wait_bound", 32'(n < 40), 1);
        check("strobe_kind", 32'(bus.alloc_res_en), 32'(exp_alloc));
        if (bus.alloc_res_en) bus.alloc_req_valid = 1'b0;
    endtask

    task automatic give_done(input int delay, input logic [3:0] sz, input logic [3:0] addr,
                             input logic exp_alloc, input logic exp_cu);
        repeat (delay) @(negedge clk);
        bus.res_table_done         = 1'b1;
        bus.cam_biggest_space_size = sz;
        bus.cam_biggest_space_addr = addr;
        @(negedge clk);
        bus.res_table_done = 1'b0;
        check("update_done", 32'(bus.update_done), 1);
        check("update_was_alloc", 32'(bus.update_was_alloc), 32'(exp_alloc));
        check("update_cu_id", 32'(bus.update_cu_id), 32'(exp_cu));
        check("biggest_size", 32'(bus.biggest_space_size), 32'(sz));
        check("biggest_addr", 32'(bus.biggest_space_addr), 32'(addr));
        check("idle_after_done", 32'(bus.seq_busy), 0);
        last_sz   = sz;
        last_addr = addr;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_a;
        int base_d;
        int base_u;

        vecs[0] = '{1'b1, 1'b1, 4'd7, 4'd3, 4'd2, 4'h9, 4'h1, 0, 1'b1, 1'b1, 1'b1};
        vecs[1] = '{1'b0, 1'b1, 4'd2, 4'd0, 4'd0, 4'h4, 4'hC, 3, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{1'b1, 1'b0, 4'hF, 4'hF, 4'd1, 4'hF, 4'h0, 1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 4'h0, 4'h0, 2, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{1'b1, 1'b0, 4'd9, 4'd8, 4'd8, 4'h3, 4'hE, 5, 1'b1, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 1'b1, 4'hF, 4'd0, 4'd0, 4'h1, 4'h1, 0, 1'b1, 1'b0, 1'b1};

        rst                        = 1'b0;
        bus.alloc_req_valid        = 1'b0;
        bus.alloc_req_cu_id        = '0;
        bus.alloc_req_wf_slot_id   = '0;
        bus.alloc_req_res_start    = '0;
        bus.alloc_req_res_size     = '0;
        bus.dealloc_req_valid      = 1'b0;
        bus.dealloc_req_cu_id      = '0;
        bus.dealloc_req_wf_slot_id = '0;
        bus.res_table_done         = 1'b0;
        bus.cam_biggest_space_size = '0;
        bus.cam_biggest_space_addr = '0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_alloc_res_en", 32'(bus.alloc_res_en), 0);
        check("rst_dealloc_res_en", 32'(bus.dealloc_res_en), 0);
        check("rst_update_done", 32'(bus.update_done), 0);
        check("rst_seq_busy", 32'(bus.seq_busy), 0);
        check("rst_alloc_ready", 32'(bus.alloc_req_ready), 1);
        check("rst_dealloc_ready", 32'(bus.dealloc_req_ready), 1);
        rst = 1'b1;
        @(negedge clk);

        // Reset while WAIT_DONE with a full FIFO
        start_alloc(1'b1, 4'd3, 4'd2, 4'd6);
        wait_strobe(1'b1);
        for (int i = 0; i < 4; i++) push_dealloc(1'b1, 4'(i));
        check("full_before_reset", 32'(bus.dealloc_req_ready), 0);
        #2 rst = 1'b0;
        #1;
        check("arst_seq_busy", 32'(bus.seq_busy), 0);
        check("arst_dealloc_ready", 32'(bus.dealloc_req_ready), 1);
        check("arst_alloc_fields", 32'({bus.alloc_cu_id, bus.alloc_wf_slot_id,
                                        bus.alloc_res_start, bus.alloc_res_size}), 0);
        check("arst_dealloc_ids", 32'({bus.dealloc_cu_id, bus.dealloc_wf_slot_id}), 0);
        check("arst_update", 32'({bus.update_done, bus.update_was_alloc, bus.update_cu_id}), 0);
        check("arst_biggest", 32'({bus.biggest_space_size, bus.biggest_space_addr}), 0);
        exp_q.delete();
        alloc_q.delete();
        @(negedge clk);
        rst = 1'b1;
        base_u = n_upd;
        base_d = n_dealloc;
        bus.res_table_done         = 1'b1;
        bus.cam_biggest_space_size = 4'h7;
        bus.cam_biggest_space_addr = 4'h7;
        @(negedge clk);
        bus.res_table_done = 1'b0;
        repeat (4) @(negedge clk);
        check("no_update_after_reset", n_upd - base_u, 0);
        check("fifo_emptied_by_reset", n_dealloc - base_d, 0);
        check("biggest_held_after_reset", 32'({bus.biggest_space_size, bus.biggest_space_addr}), 0);

        // Single alloc: strobe latency and width, done latency, CAM latch
        start_alloc(1'b0, 4'd0, 4'd0, 4'd5);
        check("alloc_ready_idle", 32'(bus.alloc_req_ready), 1);
        check("alloc_strobe_before_accept", 32'(bus.alloc_res_en), 0);
        @(negedge clk);
        check("alloc_strobe_latency", 32'(bus.alloc_res_en), 1);
        check("busy_in_wait", 32'(bus.seq_busy), 1);
        bus.alloc_req_valid = 1'b0;
        @(negedge clk);
        check("alloc_strobe_width", 32'(bus.alloc_res_en), 0);
        bus.res_table_done         = 1'b1;
        bus.cam_biggest_space_size = 4'hB;
        bus.cam_biggest_space_addr = 4'h5;
        @(negedge clk);
        bus.res_table_done = 1'b0;
        check("t2_update_done", 32'(bus.update_done), 1);
        check("t2_was_alloc", 32'(bus.update_was_alloc), 1);
        check("t2_cu", 32'(bus.update_cu_id), 0);
        check("t2_biggest_size", 32'(bus.biggest_space_size), 32'h0B);
        check("t2_biggest_addr", 32'(bus.biggest_space_addr), 32'h05);
        @(negedge clk);
        check("update_done_width", 32'(bus.update_done), 0);

        // Vector table
        for (int i = 0; i < 6; i++) begin
            if (vecs[i].is_alloc) begin
                start_alloc(vecs[i].cu, vecs[i].slot, vecs[i].start, vecs[i].size);
                check("vec_alloc_ready", 32'(bus.alloc_req_ready), 32'(vecs[i].exp_ready));
            end else begin
                check("vec_dealloc_ready", 32'(bus.dealloc_req_ready), 32'(vecs[i].exp_ready));
                push_dealloc(vecs[i].cu, vecs[i].slot);
            end
            wait_strobe(vecs[i].is_alloc);
            give_done(vecs[i].delay, vecs[i].cam_sz, vecs[i].cam_addr,
                      vecs[i].exp_was_alloc, vecs[i].exp_cu);
        end

        // Dealloc has priority over a pending alloc
        push_dealloc(1'b0, 4'd1);
        start_alloc(1'b0, 4'd2, 4'd3, 4'd4);
        check("alloc_blocked_by_fifo", 32'(bus.alloc_req_ready), 0);
        @(negedge clk);
        check("dealloc_first", 32'(bus.dealloc_res_en), 1);
        check("alloc_not_first", 32'(bus.alloc_res_en), 0);
        repeat (2) begin
            check("alloc_held_in_wait", 32'(bus.alloc_req_ready), 0);
            @(negedge clk);
        end
        give_done(0, 4'h6, 4'h9, 1'b0, 1'b0);
        check("alloc_ready_after_done", 32'(bus.alloc_req_ready), 1);
        @(negedge clk);
        check("alloc_after_dealloc", 32'(bus.alloc_res_en), 1);
        bus.alloc_req_valid = 1'b0;
        give_done(0, 4'h2, 4'hD, 1'b1, 1'b0);

        // Fill the FIFO while WAIT_DONE, refuse a 5th push, drain in order
        start_alloc(1'b1, 4'd5, 4'd1, 4'd3);
        wait_strobe(1'b1);
        for (int i = 0; i < 4; i++) push_dealloc(1'b0, 4'(i));
        check("fifo_full_after_4", 32'(bus.dealloc_req_ready), 0);
        bus.dealloc_req_valid      = 1'b1;
        bus.dealloc_req_cu_id      = 1'b0;
        bus.dealloc_req_wf_slot_id = 4'd4;
        @(negedge clk);
        check("fifo_refuses_5th", 32'(bus.dealloc_req_ready), 0);
        bus.dealloc_req_valid = 1'b0;
        base_d = n_dealloc;
        give_done(1, 4'h8, 4'h2, 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) begin
            wait_strobe(1'b0);
            give_done(i, 4'(i), 4'(i + 8), 1'b0, 1'b0);
        end
        repeat (3) @(negedge clk);
        check("drain_count", n_dealloc - base_d, 4);
        check("drain_queue_empty", exp_q.size(), 0);

        // Stray done while idle
        bus.res_table_done         = 1'b1;
        bus.cam_biggest_space_size = 4'hF;
        bus.cam_biggest_space_addr = 4'hF;
        base_u = n_upd;
        @(negedge clk);
        bus.res_table_done = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_done_no_update", n_upd - base_u, 0);
        check("idle_done_no_state", 32'(bus.seq_busy), 0);
        check("idle_done_size_held", 32'(bus.biggest_space_size), 32'(last_sz));
        check("idle_done_addr_held", 32'(bus.biggest_space_addr), 32'(last_addr));

        // Interleaved traffic wrapping the FIFO pointers
        base_a = n_alloc;
        base_d = n_dealloc;
        for (int r = 0; r < 3; r++) begin
            push_dealloc(1'(r % 2), 4'(2 * r));
            push_dealloc(1'((r + 1) % 2), 4'(2 * r + 1));
            start_alloc(1'b1, 4'(8 + r), 4'(r * 5), 4'(r + 3));
            check("alloc_stalled_by_fifo", 32'(bus.alloc_req_ready), 0);
            wait_strobe(1'b0);
            give_done(r, 4'(r), 4'(r + 1), 1'b0, 1'(r % 2));
            wait_strobe(1'b0);
            give_done(0, 4'(r + 4), 4'(r), 1'b0, 1'((r + 1) % 2));
            wait_strobe(1'b1);
            give_done(1, 4'(15 - r), 4'(r * 3), 1'b1, 1'b1);
        end
        repeat (3) @(negedge clk);
        check("mix_alloc_count", n_alloc - base_a, 3);
        check("mix_dealloc_count", n_dealloc - base_d, 6);
        check("final_dealloc_q_empty", exp_q.size(), 0);
        check("final_alloc_q_empty", alloc_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
